// File: rtl/register_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_pkg
// Description : Shared constants and port-bundle types for the integer
//               register bank and its pending scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package register_bank_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 2;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // Read-side request bundle (decode -> bank)
    typedef struct packed {
        logic [NRD_DEF-1:0]             rden;
        logic [NRD_DEF-1:0][AW_DEF-1:0] raddr;
    } register_bank_rin_type;

    // Write-side request bundle (writeback -> bank)
    typedef struct packed {
        logic [NWR_DEF-1:0]               wren;
        logic [NWR_DEF-1:0][AW_DEF-1:0]   waddr;
        logic [NWR_DEF-1:0][XLEN_DEF-1:0] wdata;
    } register_bank_win_type;

    // Read-side response bundle (bank -> decode)
    typedef struct packed {
        logic [NRD_DEF-1:0][XLEN_DEF-1:0] rdata;
        logic [NRD_DEF-1:0]               rpend;
    } register_bank_out_type;

endpackage
`default_nettype wire

// File: rtl/register_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : register_scoreboard
// Description : Per-register pending bits. Issue sets, writeback clears,
//               flush clears everything. Priority (lowest to highest):
//               writeback clear, issue set, flush. Register 0 never pends.
//               Also keeps a registered popcount of the pending vector.
// Revision    : 1.0 - initial release
// ============================================================================
module register_scoreboard #(
    parameter int NREGS = 32,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    i_clr_en,
    input  logic [NWR*AW-1:0] i_clr_addr,
    input  logic              i_issue_en,
    input  logic [AW-1:0]     i_issue_addr,
    input  logic              i_flush,
    output logic [NREGS-1:0]  o_pending,
    output logic [AW:0]       o_busy_cnt
);

    localparam logic [AW-1:0] c_ZERO_ADDR = '0;

    logic [NREGS-1:0] r_pending;
    logic [AW:0]      r_busy_cnt;
    logic [NREGS-1:0] w_next;
    logic [AW:0]      w_cnt;

    // Next pending vector: the issue is applied after the clears so a newer
    // producer keeps the register pending; flush overrides both.
    always_comb begin
        w_next = r_pending;
        for (int p = 0; p < NWR; p++) begin
            if (i_clr_en[p] && (i_clr_addr[p*AW +: AW] != c_ZERO_ADDR)) begin
                w_next[i_clr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        if (i_issue_en && (i_issue_addr != c_ZERO_ADDR)) begin
            w_next[i_issue_addr] = 1'b1;
        end
        if (i_flush) begin
            w_next = '0;
        end
        w_next[0] = 1'b0;
        w_cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt = w_cnt + (AW+1)'(w_next[i]);
        end
    end

    // Pending vector and its count advance together on each edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending  <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_pending  <= w_next;
            r_busy_cnt <= w_cnt;
        end
    end

    assign o_pending  = r_pending;
    assign o_busy_cnt = r_busy_cnt;

endmodule
`default_nettype wire

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module      : register_bank
// Description : Multi-port integer register file (NRD read, NWR write) with
//               optional write-to-read bypass and a pending scoreboard.
//               Register 0 is hardwired to zero. Higher write port wins.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank
    import register_bank_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int NWR    = NWR_DEF,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rden,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rpend,
    input  logic [NWR-1:0]      wren,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    localparam logic [AW-1:0] c_ZERO_ADDR = '0;

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_pending;

    // Register array update; later (higher-index) ports override earlier ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wren[p] && (waddr[p*AW +: AW] != c_ZERO_ADDR)) begin
                    r_regs[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
                end
            end
        end
    end

    register_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_clr_en     (wren),
        .i_clr_addr   (waddr),
        .i_issue_en   (issue_en),
        .i_issue_addr (issue_addr),
        .i_flush      (flush),
        .o_pending    (w_pending),
        .o_busy_cnt   (busy_cnt)
    );

    generate
        for (genvar r = 0; r < NRD; r++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;
            logic            w_pend;

            assign w_addr = raddr[r*AW +: AW];

            // Combinational read: stored value, optionally overridden by a
            // same-cycle write to the same non-zero register
            always_comb begin
                w_data = '0;
                w_pend = 1'b0;
                if (rden[r] && (w_addr != c_ZERO_ADDR)) begin
                    w_data = r_regs[w_addr];
                    w_pend = w_pending[w_addr];
                    if (BYPASS != 0) begin
                        for (int p = 0; p < NWR; p++) begin
                            if (wren[p] && (waddr[p*AW +: AW] == w_addr)) begin
                                w_data = wdata[p*XLEN +: XLEN];
                                w_pend = 1'b0;
                            end
                        end
                    end
                end
            end

            assign rdata[r*XLEN +: XLEN] = w_data;
            assign rpend[r]              = w_pend;
        end
    endgenerate

endmodule
`default_nettype wire
